npp_packet_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one NPP output among NUM_SRC NoC ingress lanes.

---
 rtl/npp_packet_arbiter_pkg.sv | 12 +
 rtl/npp_rr_arbiter.sv | 24 ++
 rtl/npp_packet_arbiter.sv | 110 +++++++++++
 tb/tb_npp_packet_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npp_packet_arbiter_pkg.sv
// npp_packet_arbiter_pkg: FSM encodings, flit flag struct and lane slice helper for the NPP arbiter
package npp_packet_arbiter_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;
  typedef struct packed {
    logic head;
    logic tail;
  } npp_flags_t;
  function automatic int lane_msb(input int lane, input int dw);
    return (lane + 1) * (dw + 1) - 1;
  endfunction
endpackage

// File: rtl/npp_rr_arbiter.sv
// npp_rr_arbiter: combinational rotating-priority pick of the first request at or after rr_ptr
module npp_rr_arbiter #(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);
  int idx;
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k >= NUM_SRC) ? int'(rr_ptr) + k - NUM_SRC : int'(rr_ptr) + k;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/npp_packet_arbiter.sv
// npp_packet_arbiter: packet-granular round-robin arbiter onto a registered NPP output; NPP_ARB_TIMEOUT_EN adds mid-packet abort
module npp_packet_arbiter
  import npp_packet_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_SRC     = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC*(DATA_WIDTH+1)-1:0] s_noc_data,
  input  logic [NUM_SRC-1:0]                s_is_head,
  input  logic [NUM_SRC-1:0]                s_is_tail,
  output logic [NUM_SRC-1:0]                s_ready,
  output logic                              npp_valid,
  output logic [DATA_WIDTH-1:0]             npp_data,
  output logic                              npp_head,
  output logic                              npp_tail,
  input  logic                              npp_ready,
  output logic [IW-1:0]                     grant_id,
  output logic                              busy,
  output logic                              err_proto
);
  logic [0:0]            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         nxt_ptr;
  logic                  gnt_vld;
  logic                  first;
  logic [NUM_SRC-1:0]    lane_vld;
  logic [DATA_WIDTH-1:0] lane_data [NUM_SRC];
  logic                  g_vld;
  npp_flags_t            g_flags;
  npp_flags_t            oflags;
  logic                  ld_ok;
  logic                  to_hit;
  logic                  accept;
  logic                  abort;
  logic                  pkt_done;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign lane_vld[i]  = s_noc_data[lane_msb(i, DATA_WIDTH)];
    assign lane_data[i] = s_noc_data[lane_msb(i, DATA_WIDTH)-1 -: DATA_WIDTH];
  end
  npp_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req    (lane_vld & s_is_head),
    .rr_ptr (rr_ptr),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );
  assign busy      = (state == ST_PKT);
  assign ld_ok     = ~npp_valid | npp_ready;
  assign g_vld     = lane_vld[grant_id];
  assign g_flags   = '{head: s_is_head[grant_id], tail: s_is_tail[grant_id]};
  assign accept    = busy & g_vld & ld_ok & ~to_hit;
  assign abort     = busy & to_hit & ld_ok;
  assign pkt_done  = (accept & g_flags.tail) | abort;
  assign nxt_ptr   = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
  assign s_ready   = (busy & ld_ok & ~to_hit) ? NUM_SRC'(1) << grant_id : '0;
  assign npp_head  = oflags.head;
  assign npp_tail  = oflags.tail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      first     <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (state == ST_IDLE && gnt_vld) begin
        state    <= ST_PKT;
        grant_id <= gnt_idx;
        first    <= 1'b1;
      end else if (pkt_done) begin
        state  <= ST_IDLE;
        rr_ptr <= nxt_ptr;
      end
      if (accept) first <= 1'b0;
      // a head after the packet's first beat is a protocol error but is still forwarded
      err_proto <= (accept & g_flags.head & ~first) | abort;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npp_valid <= 1'b0;
      npp_data  <= '0;
      oflags    <= '0;
    end else if (accept || abort) begin
      npp_valid <= 1'b1;
      npp_data  <= accept ? lane_data[grant_id] : '0;
      oflags    <= accept ? g_flags : '{head: 1'b0, tail: 1'b1};
    end else if (npp_ready) begin
      npp_valid <= 1'b0;
    end
  end
`ifdef NPP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else if (!busy || accept) to_cnt <= '0;
    else if (!g_vld && !to_hit) to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign to_hit = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif
endmodule

// File: tb/tb_npp_packet_arbiter.sv
// tb_npp_packet_arbiter: directed self-checking bench for npp_packet_arbiter (timeout scenario under NPP_ARB_TIMEOUT_EN)
module tb_npp_packet_arbiter;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic npp_ready;
  logic [NS*(DW+1)-1:0] s_noc_data;
  logic [NS-1:0] lane_v = '0;
  logic [NS-1:0] lane_h = '0;
  logic [NS-1:0] lane_t = '0;
  logic [DW-1:0] lane_d [NS];
  logic [NS-1:0] s_ready;
  logic npp_valid, npp_head, npp_tail, busy, err_proto;
  logic [DW-1:0] npp_data;
  logic [1:0] grant_id;
  logic [17:0] q [NS][$];
  logic [17:0] obs_f [$];
  int obs_c [$];
  logic [NS-1:0] fired = '0;
  int cyc = 0;
  int err_cnt = 0;
  logic [DW-1:0] err_data;
  logic err_head;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NS; g++) begin : g_lane
    assign s_noc_data[g*(DW+1) +: DW+1] = {lane_v[g], lane_d[g]};
  end
  npp_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_noc_data(s_noc_data), .s_is_head(lane_h), .s_is_tail(lane_t),
    .s_ready(s_ready), .npp_valid(npp_valid), .npp_data(npp_data), .npp_head(npp_head),
    .npp_tail(npp_tail), .npp_ready(npp_ready), .grant_id(grant_id), .busy(busy), .err_proto(err_proto)
  );
  always @(posedge clk) cyc <= cyc + 1;
  // lane sources pop on the handshake seen before the last edge; the output monitor logs transfers
  always @(negedge clk) begin
    if (!rst_n) fired = '0;
    for (int i = 0; i < NS; i++) if (fired[i] && q[i].size() > 0) void'(q[i].pop_front());
    for (int i = 0; i < NS; i++) begin
      if (q[i].size() > 0) begin
        lane_v[i] = 1'b1;
        {lane_h[i], lane_t[i], lane_d[i]} = q[i][0];
      end else begin
        lane_v[i] = 1'b0;
        lane_h[i] = 1'b0;
        lane_t[i] = 1'b0;
        lane_d[i] = '0;
      end
    end
    #1;
    fired = rst_n ? (s_ready & lane_v) : '0;
    if (rst_n && npp_valid && npp_ready) begin
      obs_f.push_back({npp_head, npp_tail, npp_data});
      obs_c.push_back(cyc);
    end
    if (err_proto) begin
      err_cnt++;
      err_data = npp_data;
      err_head = npp_head;
    end
  end
  function automatic logic [17:0] fl(input int ln, input int pk, input int b, input bit h, input bit t);
    return {h, t, 4'(ln), 4'(pk), 8'(b)};
  endfunction
  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (obs_f.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
    end
  endtask
  task automatic settle_clear;
    repeat (3) @(negedge clk);
    #2;
    obs_f.delete();
    obs_c.delete();
    err_cnt = 0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (npp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", npp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (s_ready !== 4'h0) begin n_err++; $display("FAIL reset_sready got=%h exp=0", s_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    n_cmp++; if ({npp_head, npp_tail, npp_data, err_proto} !== 19'h0) begin n_err++; $display("FAIL reset_out got=%b%b%h%b exp=0", npp_head, npp_tail, npp_data, err_proto); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    n_cmp++; if ({npp_valid, busy, s_ready} !== 6'h0) begin n_err++; $display("FAIL post_reset_idle got=%b%b%h exp=0", npp_valid, busy, s_ready); end
  endtask
  task automatic test_single_packet;
    int c0;
    bit ok;
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) q[2].push_back(fl(2, 1, b, b == 0, b == 3));
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #2;
      if (cyc - c0 == 2) begin
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL sp_grant got=%0d exp=2", grant_id); end
        n_cmp++; if (s_ready !== 4'b0100) begin n_err++; $display("FAIL sp_sready got=%b exp=0100", s_ready); end
      end
      if (cyc - c0 == 4) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sp_busy_mid got=%b exp=1", busy); end end
      if (cyc - c0 == 5) begin n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sp_busy_after_tail got=%b exp=0", busy); end end
    end
    wait_obs(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sp_count got=%0d exp=4", obs_f.size()); end
    if (ok) for (int b = 0; b < 4; b++) begin
      n_cmp++; if (obs_f[b] !== fl(2, 1, b, b == 0, b == 3)) begin n_err++; $display("FAIL sp_beat%0d got=%h exp=%h", b, obs_f[b], fl(2, 1, b, b == 0, b == 3)); end
      n_cmp++; if (obs_c[b] !== c0 + 2 + b) begin n_err++; $display("FAIL sp_time%0d got=%0d exp=%0d", b, obs_c[b] - c0, 2 + b); end
    end
    settle_clear();
  endtask
  task automatic test_rr_order;
    bit ok;
    @(posedge clk);
    #2;
    q[3].push_back(fl(3, 2, 0, 1, 1));
    wait_obs(1, ok);
    n_cmp++; if (!ok || obs_f[0] !== fl(3, 2, 0, 1, 1)) begin n_err++; $display("FAIL rr_prep got=%0d beats exp=1 lane3 single", obs_f.size()); end
    settle_clear();
    for (int rep = 0; rep < 2; rep++) begin
      @(posedge clk);
      #2;
      for (int ln = 0; ln < NS; ln++) q[ln].push_back(fl(ln, 3, rep, 1, 1));
      wait_obs(4, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_count rep%0d got=%0d exp=4", rep, obs_f.size()); end
      if (ok) for (int k = 0; k < 4; k++) begin
        n_cmp++; if (obs_f[k] !== fl(k, 3, rep, 1, 1)) begin n_err++; $display("FAIL rr_order rep%0d slot%0d got=%h exp=%h", rep, k, obs_f[k], fl(k, 3, rep, 1, 1)); end
        if (k > 0) begin n_cmp++; if (obs_c[k] - obs_c[k-1] !== 2) begin n_err++; $display("FAIL rr_gap rep%0d slot%0d got=%0d exp=2", rep, k, obs_c[k] - obs_c[k-1]); end end
      end
      settle_clear();
    end
  endtask
  task automatic test_backpressure;
    bit ok;
    logic [17:0] snap;
    @(posedge clk);
    #2;
    for (int b = 0; b < 6; b++) q[0].push_back(fl(0, 4, b, b == 0, b == 5));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (obs_f.size() >= 2) break;
    end
    @(negedge clk);
    npp_ready = 1'b0;
    #2;
    snap = {npp_head, npp_tail, npp_data};
    n_cmp++; if (snap !== fl(0, 4, 2, 0, 0) || npp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_beat got=%b/%h exp=1/%h", npp_valid, snap, fl(0, 4, 2, 0, 0)); end
    n_cmp++; if (s_ready !== 4'h0) begin n_err++; $display("FAIL bp_sready0 got=%b exp=0000", s_ready); end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      #2;
      n_cmp++; if ({npp_valid, npp_head, npp_tail, npp_data} !== {1'b1, snap}) begin n_err++; $display("FAIL bp_stable%0d got=%b/%h exp=1/%h", k, npp_valid, {npp_head, npp_tail, npp_data}, snap); end
      n_cmp++; if (s_ready !== 4'h0) begin n_err++; $display("FAIL bp_sready%0d got=%b exp=0000", k, s_ready); end
    end
    @(negedge clk);
    npp_ready = 1'b1;
    wait_obs(6, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_count got=%0d exp=6", obs_f.size()); end
    if (ok) for (int b = 0; b < 6; b++) begin
      n_cmp++; if (obs_f[b] !== fl(0, 4, b, b == 0, b == 5)) begin n_err++; $display("FAIL bp_beat%0d got=%h exp=%h", b, obs_f[b], fl(0, 4, b, b == 0, b == 5)); end
    end
    settle_clear();
    n_cmp++; if (obs_f.size() !== 0) begin n_err++; $display("FAIL bp_extra got=%0d exp=0", obs_f.size()); end
  endtask
  task automatic test_headless;
    @(posedge clk);
    #2;
    q[2].push_back(fl(2, 5, 0, 0, 1));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #2;
      n_cmp++; if ({busy, s_ready} !== 5'h0) begin n_err++; $display("FAIL hl_hold%0d got=%b%b exp=0", k, busy, s_ready); end
    end
    n_cmp++; if (err_cnt !== 0) begin n_err++; $display("FAIL hl_err got=%0d exp=0", err_cnt); end
    @(posedge clk);
    #2;
    q[2].delete();
    settle_clear();
  endtask
  task automatic test_no_interleave;
    bit ok;
    int held;
    held = 0;
    @(posedge clk);
    #2;
    for (int b = 0; b < 3; b++) q[1].push_back(fl(1, 6, b, b == 0, b == 2));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (busy && grant_id == 2'd1) break;
    end
    @(posedge clk);
    #2;
    for (int b = 0; b < 2; b++) q[0].push_back(fl(0, 7, b, b == 0, b == 1));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #2;
      if (busy && grant_id == 2'd1) begin
        held++;
        n_cmp++; if (s_ready[0] !== 1'b0) begin n_err++; $display("FAIL ni_lane0_ready got=%b exp=0", s_ready[0]); end
      end
      if (obs_f.size() >= 5) break;
    end
    n_cmp++; if (held < 1) begin n_err++; $display("FAIL ni_overlap got=%0d exp>=1", held); end
    wait_obs(5, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ni_count got=%0d exp=5", obs_f.size()); end
    if (ok) for (int k = 0; k < 5; k++) begin
      n_cmp++; if (obs_f[k] !== (k < 3 ? fl(1, 6, k, k == 0, k == 2) : fl(0, 7, k - 3, k == 3, k == 4))) begin n_err++; $display("FAIL ni_beat%0d got=%h", k, obs_f[k]); end
    end
    settle_clear();
  endtask
  task automatic test_double_head;
    bit ok;
    logic [17:0] exp [4];
    exp[0] = fl(3, 8, 0, 1, 0);
    exp[1] = fl(3, 8, 1, 0, 0);
    exp[2] = fl(3, 8, 2, 1, 0);
    exp[3] = fl(3, 8, 3, 0, 1);
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) q[3].push_back(exp[b]);
    wait_obs(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dh_count got=%0d exp=4", obs_f.size()); end
    if (ok) for (int b = 0; b < 4; b++) begin
      n_cmp++; if (obs_f[b] !== exp[b]) begin n_err++; $display("FAIL dh_beat%0d got=%h exp=%h", b, obs_f[b], exp[b]); end
    end
    n_cmp++; if (err_cnt !== 1) begin n_err++; $display("FAIL dh_err_count got=%0d exp=1", err_cnt); end
    n_cmp++; if ({err_head, err_data} !== {1'b1, exp[2][15:0]}) begin n_err++; $display("FAIL dh_err_align got=%b/%h exp=1/%h", err_head, err_data, exp[2][15:0]); end
    settle_clear();
  endtask
`ifdef NPP_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    @(posedge clk);
    #2;
    q[0].push_back(fl(0, 9, 0, 1, 0));
    wait_obs(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL to_count got=%0d exp=2", obs_f.size()); end
    if (ok) begin
      n_cmp++; if (obs_f[0] !== fl(0, 9, 0, 1, 0)) begin n_err++; $display("FAIL to_head got=%h exp=%h", obs_f[0], fl(0, 9, 0, 1, 0)); end
      n_cmp++; if (obs_f[1] !== 18'h10000) begin n_err++; $display("FAIL to_synth got=%h exp=10000", obs_f[1]); end
      n_cmp++; if (obs_c[1] - obs_c[0] !== 9) begin n_err++; $display("FAIL to_delay got=%0d exp=9", obs_c[1] - obs_c[0]); end
    end
    @(negedge clk);
    #2;
    n_cmp++; if (err_cnt !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL to_err_idle got=%0d/%b exp=1/0", err_cnt, busy); end
    settle_clear();
  endtask
`endif
  task automatic test_async_reset;
    bit ok;
    @(posedge clk);
    #2;
    for (int b = 0; b < 4; b++) q[2].push_back(fl(2, 10, b, b == 0, b == 3));
    wait_obs(1, ok);
    @(posedge clk);
    #3;
    n_cmp++; if (npp_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ar_pre got=%b/%b exp=1/1", npp_valid, busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({npp_valid, busy, s_ready, grant_id} !== 8'h0) begin n_err++; $display("FAIL ar_clear got=%b%b%b%b exp=0", npp_valid, busy, s_ready, grant_id); end
    for (int i = 0; i < NS; i++) q[i].delete();
    fired = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    obs_f.delete();
    obs_c.delete();
    q[3].push_back(fl(3, 11, 0, 1, 1));
    q[0].push_back(fl(0, 11, 0, 1, 1));
    wait_obs(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ar_count got=%0d exp=2", obs_f.size()); end
    if (ok) begin
      n_cmp++; if (obs_f[0] !== fl(0, 11, 0, 1, 1) || obs_f[1] !== fl(3, 11, 0, 1, 1)) begin n_err++; $display("FAIL ar_rr_reset got=%h,%h exp=%h,%h", obs_f[0], obs_f[1], fl(0, 11, 0, 1, 1), fl(3, 11, 0, 1, 1)); end
    end
    settle_clear();
  endtask
  initial begin
    npp_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_rr_order();
    test_backpressure();
    test_headless();
    test_no_interleave();
    test_double_head();
`ifdef NPP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
